pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Generic parametrised pipeline-stage register for the RISC-V pipeline. It is the successor to the fixed per-stage registers and replaces hard-coded stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data bundle and a control bundle.
- Adds a valid/ready handshake, stall back-pressure, synchronous flush (bubble insertion) and an optional one-entry skid slot for full throughput with a registered in_ready.
- Latency 1 cycle; order preserved.

Parameters:
DATA_W, 96, width of datapath bundle (e.g. PC+4, ALU result, load data)
CTRL_W, 8, width of control bundle (RegWrite, ResultSrc, rd, ...); forced to 0 in bubbles
SKID, 1, 1 = skid slot present and in_ready registered; 0 = no skid, in_ready combinational
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_data  in  DATA_W  upstream datapath bundle
in_ctrl  in  CTRL_W  upstream control bundle
flush  in  1  synchronous kill of all held beats
out_valid  out  1  beat held for downstream
out_ready  in  1  downstream accepts (0 = stall)
out_data  out  DATA_W  held datapath bundle
out_ctrl  out  CTRL_W  held control bundle; 0 whenever out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
bubble_cnt  out  CNT_W  cycles with out_valid=0

Behaviour:
- Reset: out_valid=0, out_data=0, out_ctrl=0, skid slot empty/zero, counters=0, in_ready=0 while rst is high. From the first clock after release, in_ready=1.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Deliver = out_valid & out_ready.
  - in_valid/in_data/in_ctrl may change freely while in_ready=0.
- SKID=0:
  - in_ready = out_ready | ~out_valid.
  - On accept, main register loads in_* next edge.
  - On deliver without accept, out_valid clears and out_ctrl is zeroed.
- SKID=1:
  - in_ready = ~skid_valid (registered).
  - When the main register is empty or delivering, it loads from the skid slot if that is valid, else from the input if accepting; the skid slot is then cleared.
  - If main is full and not delivering and an accept occurs, the beat goes to the skid slot.
  - Sustains 1 beat/cycle; after out_ready drops, exactly one further beat is absorbed, then in_ready=0.
- Flush (priority over everything except rst):
  - Next edge: out_valid=0, out_ctrl=0, skid cleared, in_ready=1 (SKID=1).
  - A beat accepted in the flush cycle is discarded.
  - out_data holds its last value (don't-care).
- Stall: out_valid=1 and out_ready=0 means out_data/out_ctrl are held bit-stable.
- Invariant: out_valid=0 implies out_ctrl=0. A bubble never writes the register file.
- rst mid-transfer: immediate clear of all state; in-flight beats are lost.

Optional Feature:
PIPE_STAGE_PERF_EN
- Defined: stall_cnt and bubble_cnt increment per the port definitions, saturate at all-ones, are reset by rst only (not by flush), and do not count while rst is high.
- Undefined: both ports are tied to constant 0 and the counter logic is not built.

Decomposition:
- Shared package pipe_pkg:
  - Default widths (XLEN=32, REG_ADDR_W=5, RESULT_SRC_W=2).
  - Control-bundle typedef / field offsets per stage.
  - CTRL_BUBBLE constant (all zero).
- Sub-module pipe_perf_cnt: a single saturating counter with enable, instantiated twice under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset then stream: in_data=0x11,0x22,0x33 on consecutive cycles, out_ready=1 → out_data 0x11,0x22,0x33 one cycle later each; in_ready stays 1.
- Stall with SKID=1: stream 0xA0..0xA3, drop out_ready during 0xA1 for 3 cycles → 0xA1 held stable, 0xA2 absorbed in skid, in_ready=0 for 2 cycles; release gives 0xA1,0xA2,0xA3 in order with no loss or duplication.
- Same stall with SKID=0 → in_ready follows out_ready combinationally, no beat lost.
- Flush while main and skid full (in_ctrl=0x85) → next cycle out_valid=0, out_ctrl=0x00, in_ready=1; a concurrent input beat never appears at the output.
- Async rst pulse mid-cycle during a stream → outputs zero immediately, with no clock edge required.
- PIPE_STAGE_PERF_EN: 5 stall cycles and 3 idle cycles → stall_cnt=5, bubble_cnt=3 (plus idle cycles after reset); with CNT_W=4, forcing 20 stalls → stall_cnt=15. Without the macro both read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register: default widths,
// the write-back control bundle layout and the all-zero bubble encoding.
package pipe_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned REG_ADDR_W   = 5;
   localparam int unsigned RESULT_SRC_W = 2;

   localparam int unsigned DATA_W_DEF = 96;
   localparam int unsigned CTRL_W_DEF = 8;
   localparam int unsigned CNT_W_DEF  = 32;

   typedef enum logic [1:0] {
      StageIfId,
      StageIdEx,
      StageExMem,
      StageMemWb
   } stage_e;

   // Control bundle carried from ID onward; the MSB gates register-file writes.
   typedef struct packed {
      logic                    reg_write;
      logic [RESULT_SRC_W-1:0] result_src;
      logic [REG_ADDR_W-1:0]   rd;
   } wb_ctrl_t;

   localparam int unsigned WB_CTRL_W          = $bits(wb_ctrl_t);
   localparam int unsigned CTRL_RD_LSB        = 0;
   localparam int unsigned CTRL_RESULT_SRC_LSB = REG_ADDR_W;
   localparam int unsigned CTRL_REG_WRITE_BIT  = REG_ADDR_W + RESULT_SRC_W;

   localparam logic [WB_CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with enable; holds at all-ones once reached.
module pipe_perf_cnt #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline-stage register with flush and optional skid slot.
// Performance counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CTRL_W = CTRL_W_DEF,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [CTRL_W-1:0] CtrlBubble = CTRL_W'(CTRL_BUBBLE);

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic              accept;

   assign accept = in_valid & in_ready;

   generate
      if (SKID != 0) begin : g_skid
         logic              skid_valid_q, skid_valid_d;
         logic [DATA_W-1:0] skid_data_q, skid_data_d;
         logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
         logic              ready_q;

         always_comb begin
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
            main_ctrl_d  = main_ctrl_q;
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            skid_ctrl_d  = skid_ctrl_q;
            if (flush) begin
               main_valid_d = 1'b0;
               main_ctrl_d  = CtrlBubble;
               skid_valid_d = 1'b0;
               skid_ctrl_d  = CtrlBubble;
            end else if (!main_valid_q || out_ready) begin
               // Skid is older than any input beat; in_ready is low while it is full.
               if (skid_valid_q) begin
                  main_valid_d = 1'b1;
                  main_data_d  = skid_data_q;
                  main_ctrl_d  = skid_ctrl_q;
                  skid_valid_d = 1'b0;
                  skid_ctrl_d  = CtrlBubble;
               end else if (accept) begin
                  main_valid_d = 1'b1;
                  main_data_d  = in_data;
                  main_ctrl_d  = in_ctrl;
               end else begin
                  main_valid_d = 1'b0;
                  main_ctrl_d  = CtrlBubble;
               end
            end else if (accept) begin
               skid_valid_d = 1'b1;
               skid_data_d  = in_data;
               skid_ctrl_d  = in_ctrl;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skid_valid_q <= 1'b0;
               skid_data_q  <= '0;
               skid_ctrl_q  <= '0;
               ready_q      <= 1'b0;
            end else begin
               skid_valid_q <= skid_valid_d;
               skid_data_q  <= skid_data_d;
               skid_ctrl_q  <= skid_ctrl_d;
               ready_q      <= ~skid_valid_d;
            end
         end

         assign in_ready = ready_q;
      end else begin : g_noskid
         logic alive_q;

         always_comb begin
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
            main_ctrl_d  = main_ctrl_q;
            if (flush) begin
               main_valid_d = 1'b0;
               main_ctrl_d  = CtrlBubble;
            end else if (accept) begin
               main_valid_d = 1'b1;
               main_data_d  = in_data;
               main_ctrl_d  = in_ctrl;
            end else if (main_valid_q && out_ready) begin
               main_valid_d = 1'b0;
               main_ctrl_d  = CtrlBubble;
            end
         end

         // Keeps in_ready low while rst is high and until the first clock after it.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               alive_q <= 1'b0;
            end else begin
               alive_q <= 1'b1;
            end
         end

         assign in_ready = alive_q & (out_ready | ~main_valid_q);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_ctrl_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
      end
   end

   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign out_ctrl  = main_ctrl_q;

`ifdef PIPE_STAGE_PERF_EN
   pipe_perf_cnt #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk(clk),
      .rst(rst),
      .en (main_valid_q & ~out_ready),
      .cnt(stall_cnt)
   );

   pipe_perf_cnt #(
      .W(CNT_W)
   ) u_bubble_cnt (
      .clk(clk),
      .rst(rst),
      .en (~main_valid_q),
      .cnt(bubble_cnt)
   );
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, no skid, skid with 4-bit counters)
// each compared every cycle against a queue-based model of the stage.
module tb_pipe_stage_reg;

   localparam int unsigned DW = 96;
   localparam int unsigned CW = 8;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   logic out_ready;
   logic flush;
   logic          iv[3];
   logic [DW-1:0] id[3];
   logic [CW-1:0] ic[3];
   logic          ir[3];
   logic          ov[3];
   logic [DW-1:0] od[3];
   logic [CW-1:0] oc[3];
   logic [31:0]   sc0, bc0, sc1, bc1;
   logic [3:0]    sc2, bc2;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(32)) u_s1 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
      .in_ctrl(ic[0]), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(od[0]), .out_ctrl(oc[0]), .stall_cnt(sc0), .bubble_cnt(bc0)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(32)) u_s0 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
      .in_ctrl(ic[1]), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(od[1]), .out_ctrl(oc[1]), .stall_cnt(sc1), .bubble_cnt(bc1)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_c4 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
      .in_ctrl(ic[2]), .flush(flush), .out_valid(ov[2]), .out_ready(out_ready),
      .out_data(od[2]), .out_ctrl(oc[2]), .stall_cnt(sc2), .bubble_cnt(bc2)
   );

   // Model: each stage is a FIFO of held beats (capacity 2 with skid, 1 without).
   beat_t           mq[3][$];
   beat_t           pend[3][$];
   bit              alive[3];
   bit              acc_m[3];
   longint unsigned st_m[3];
   longint unsigned bu_m[3];
   bit              src_v[3];
   beat_t           src_b[3];
   bit              rand_src;
   int              checks;
   int              errors;

   function automatic bit skid_of(int i);
      return i != 1;
   endfunction

   function automatic longint unsigned cmax(int i);
      return (i == 2) ? 64'd15 : 64'hFFFF_FFFF;
   endfunction

   function automatic bit m_ready(int i);
      if (!alive[i]) return 1'b0;
      if (skid_of(i)) return mq[i].size() < 2;
      return (mq[i].size() == 0) || out_ready;
   endfunction

   function automatic logic [31:0] got_st(int i);
      if (i == 0) return sc0;
      if (i == 1) return sc1;
      return {28'd0, sc2};
   endfunction

   function automatic logic [31:0] got_bu(int i);
      if (i == 0) return bc0;
      if (i == 1) return bc1;
      return {28'd0, bc2};
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      b.d = {$urandom, $urandom, $urandom};
      b.c = CW'($urandom_range(1, 255));
      return b;
   endfunction

   function automatic beat_t mk(logic [31:0] d, logic [7:0] c);
      beat_t b;
      b.d = DW'(d);
      b.c = c;
      return b;
   endfunction

   task automatic chk(string nm, int i, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, i, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mq[i].delete();
         alive[i] = 1'b0;
         acc_m[i] = 1'b0;
         st_m[i]  = 0;
         bu_m[i]  = 0;
      end
   endtask

   task automatic model_step();
      bit a, dl;
      for (int i = 0; i < 3; i++) begin
         a  = src_v[i] && m_ready(i);
         dl = (mq[i].size() != 0) && out_ready;
         if (mq[i].size() != 0 && !out_ready && st_m[i] < cmax(i)) st_m[i]++;
         if (mq[i].size() == 0 && bu_m[i] < cmax(i)) bu_m[i]++;
         if (flush) begin
            mq[i].delete();
         end else begin
            if (dl) void'(mq[i].pop_front());
            if (a) mq[i].push_back(src_b[i]);
         end
         acc_m[i] = a;
         alive[i] = 1'b1;
      end
   endtask

   task automatic compare_all();
      beat_t f;
      bit    v;
      for (int i = 0; i < 3; i++) begin
         v = mq[i].size() != 0;
         f = '0;
         if (v) f = mq[i][0];
         chk("in_ready", i, 128'(ir[i]), 128'(m_ready(i)));
         chk("out_valid", i, 128'(ov[i]), 128'(v));
         chk("out_ctrl", i, 128'(oc[i]), v ? 128'(f.c) : 128'd0);
         if (v) chk("out_data", i, 128'(od[i]), 128'(f.d));
`ifdef PIPE_STAGE_PERF_EN
         chk("stall_cnt", i, 128'(got_st(i)), 128'(st_m[i]));
         chk("bubble_cnt", i, 128'(got_bu(i)), 128'(bu_m[i]));
`else
         chk("stall_cnt", i, 128'(got_st(i)), 128'd0);
         chk("bubble_cnt", i, 128'(got_bu(i)), 128'd0);
`endif
      end
   endtask

   // Upstream holds its beat until the model saw it accepted.
   task automatic drive_src();
      for (int i = 0; i < 3; i++) begin
         if (!src_v[i] || acc_m[i]) begin
            if (pend[i].size() != 0) begin
               src_b[i] = pend[i].pop_front();
               src_v[i] = 1'b1;
            end else if (rand_src && $urandom_range(99) < 70) begin
               src_b[i] = rand_beat();
               src_v[i] = 1'b1;
            end else begin
               src_v[i] = 1'b0;
            end
         end
         iv[i] = src_v[i];
         id[i] = src_b[i].d;
         ic[i] = src_b[i].c;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic cyc(bit ordy, bit fl);
      out_ready = ordy;
      flush     = fl;
      drive_src();
      tick();
   endtask

   task automatic push_all(beat_t b);
      for (int i = 0; i < 3; i++) pend[i].push_back(b);
   endtask

   initial begin
      longint unsigned base;
      checks    = 0;
      errors    = 0;
      rand_src  = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b0;
      rst       = 1'b1;
      for (int i = 0; i < 3; i++) begin
         src_v[i] = 1'b0;
         src_b[i] = '0;
      end
      model_reset();

      cyc(1, 0);
      cyc(1, 0);
      for (int i = 0; i < 3; i++) begin
         chk("rst_in_ready", i, 128'(ir[i]), 128'd0);
         chk("rst_out_data", i, 128'(od[i]), 128'd0);
      end
      rst = 1'b0;
      cyc(1, 0);
      chk("ready_after_rst", 0, 128'(ir[0]), 128'd1);
      chk("ready_after_rst", 1, 128'(ir[1]), 128'd1);

      // Plain stream.
      push_all(mk(32'h11, 8'h01));
      push_all(mk(32'h22, 8'h02));
      push_all(mk(32'h33, 8'h03));
      cyc(1, 0);
      chk("stream0", 0, 128'(od[0]), 128'h11);
      chk("stream0", 1, 128'(od[1]), 128'h11);
      cyc(1, 0);
      chk("stream1", 0, 128'(od[0]), 128'h22);
      chk("stream1_ready", 0, 128'(ir[0]), 128'd1);
      cyc(1, 0);
      chk("stream2", 0, 128'(od[0]), 128'h33);
      chk("stream2", 1, 128'(od[1]), 128'h33);
      cyc(1, 0);
      cyc(1, 0);

      // Stall while A1 is presented.
      for (int k = 0; k < 4; k++) push_all(mk(32'hA0 + k, 8'h10 + 8'(k)));
      cyc(1, 0);
      cyc(1, 0);
      cyc(0, 0);
      chk("stall_hold", 0, 128'(od[0]), 128'hA1);
      chk("stall_ready", 0, 128'(ir[0]), 128'd0);
      chk("stall_hold", 1, 128'(od[1]), 128'hA1);
      chk("stall_ready", 1, 128'(ir[1]), 128'd0);
      cyc(0, 0);
      chk("stall_hold2", 0, 128'(od[0]), 128'hA1);
      chk("stall_ready2", 0, 128'(ir[0]), 128'd0);
      cyc(0, 0);
      out_ready = 1'b1;
      #1;
      chk("s0_ready_comb", 1, 128'(ir[1]), 128'd1);
      repeat (6) cyc(1, 0);

      // Flush with main and skid full.
      for (int k = 0; k < 3; k++) push_all(mk(32'hB0 + k, 8'h85));
      cyc(0, 0);
      cyc(0, 0);
      chk("skid_full_ready", 0, 128'(ir[0]), 128'd0);
      cyc(1, 1);
      for (int i = 0; i < 3; i++) begin
         chk("flush_valid", i, 128'(ov[i]), 128'd0);
         chk("flush_ctrl", i, 128'(oc[i]), 128'd0);
         chk("flush_ready", i, 128'(ir[i]), 128'd1);
      end
      cyc(1, 0);
      chk("post_flush_data", 1, 128'(od[1]), 128'hB2);
      chk("post_flush_data", 0, 128'(od[0]), 128'hB2);
      repeat (4) cyc(1, 0);

      // Idle then stall windows for the counters.
      base = bu_m[0];
      repeat (3) cyc(1, 0);
`ifdef PIPE_STAGE_PERF_EN
      chk("bubble_delta", 0, 128'(got_bu(0)), 128'(base + 3));
`else
      chk("bubble_off", 0, 128'(got_bu(0)), 128'd0);
`endif
      push_all(mk(32'hC0, 8'h42));
      cyc(1, 0);
      base = st_m[0];
      repeat (5) cyc(0, 0);
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_delta", 0, 128'(got_st(0)), 128'(base + 5));
`else
      chk("stall_off", 0, 128'(got_st(0)), 128'd0);
`endif
      repeat (15) cyc(0, 0);
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_sat4", 2, 128'(sc2), 128'd15);
`else
      chk("stall_off4", 2, 128'(sc2), 128'd0);
`endif
      repeat (4) cyc(1, 0);

      // Randomized traffic.
      rand_src = 1'b1;
      repeat (400) cyc($urandom_range(99) < 70, $urandom_range(99) < 4);

      // Asynchronous reset between edges.
      out_ready = 1'b1;
      flush     = 1'b0;
      drive_src();
      @(posedge clk);
      model_step();
      #2;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("async_valid", i, 128'(ov[i]), 128'd0);
         chk("async_ctrl", i, 128'(oc[i]), 128'd0);
         chk("async_data", i, 128'(od[i]), 128'd0);
         chk("async_ready", i, 128'(ir[i]), 128'd0);
         chk("async_stall", i, 128'(got_st(i)), 128'd0);
         chk("async_bubble", i, 128'(got_bu(i)), 128'd0);
      end
      model_reset();
      cyc(1, 0);
      cyc(1, 0);
      rst = 1'b0;
      repeat (150) cyc($urandom_range(99) < 70, $urandom_range(99) < 4);
      rand_src = 1'b0;
      repeat (5) cyc(1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
